// File: rtl/float_discriminant_collector.sv
// Collects discriminant-pipeline results into a first-word-fall-through FIFO.
// It tracks outstanding issues so that the issuer never has more work in flight
// than there is free buffer space. It also flags protocol violations and counts
// error results.
module float_discriminant_collector #(
    parameter int FLEN  = 64,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arg_vld,
    input  logic            res_vld,
    input  logic [FLEN-1:0] res,
    input  logic            res_negative,
    input  logic            err,
    output logic            can_issue,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [FLEN-1:0] out_res,
    output logic            out_negative,
    output logic            out_err,
    output logic [7:0]      err_count,
    output logic            proto_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = FLEN + 2;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] occupancy_q, occupancy_d;
    logic [CW-1:0] inFlight_q, inFlight_d;
    logic [7:0]    errCount_q, errCount_d;
    logic          protoErr_q, protoErr_d;

    logic          isFull;
    logic          isEmpty;
    logic          doPop;
    logic          doPush;
    logic [CW:0]   creditSum;
    logic [EW-1:0] headEntry;

    // Handshake decode. A full FIFO still accepts a result when the head leaves in the same cycle.
    always_comb begin
        isFull    = (occupancy_q == CW'(DEPTH));
        isEmpty   = (occupancy_q == '0);
        doPop     = !isEmpty && out_rdy;
        doPush    = res_vld && (!isFull || doPop);
        creditSum = {1'b0, occupancy_q} + {1'b0, inFlight_q};
        can_issue = (creditSum < (CW + 1)'(DEPTH));
    end

    // Next-state for pointers, occupancy, outstanding issues, error counter and the sticky flag.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        occupancy_d = occupancy_q;
        inFlight_d  = inFlight_q;
        errCount_d  = errCount_q;
        protoErr_d  = protoErr_q;

        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end

        case ({doPush, doPop})
            2'b10:   occupancy_d = occupancy_q + CW'(1);
            2'b01:   occupancy_d = occupancy_q - CW'(1);
            default: occupancy_d = occupancy_q;
        endcase

        if (arg_vld && !res_vld) begin
            if (inFlight_q != CW'(DEPTH)) begin
                inFlight_d = inFlight_q + CW'(1);
            end
        end else if (!arg_vld && res_vld) begin
            if (inFlight_q != '0) begin
                inFlight_d = inFlight_q - CW'(1);
            end
        end

        if (doPush && err && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end

        if ((arg_vld && !can_issue) ||
            (res_vld && !arg_vld && (inFlight_q == '0)) ||
            (res_vld && !doPush)) begin
            protoErr_d = 1'b1;
        end
    end

    // Control and accounting registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            occupancy_q <= '0;
            inFlight_q  <= '0;
            errCount_q  <= '0;
            protoErr_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            occupancy_q <= occupancy_d;
            inFlight_q  <= inFlight_d;
            errCount_q  <= errCount_d;
            protoErr_q  <= protoErr_d;
        end
    end

    // Entry storage. It is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush) begin
            mem_q[wrPtr_q] <= {err, res_negative, res};
        end
    end

    // The head entry is presented straight from storage, so there is no bypass from the inputs.
    always_comb begin
        headEntry    = mem_q[rdPtr_q];
        out_vld      = !isEmpty;
        out_res      = headEntry[FLEN-1:0];
        out_negative = headEntry[FLEN];
        out_err      = headEntry[FLEN+1];
        err_count    = errCount_q;
        proto_err    = protoErr_q;
    end

endmodule

// File: tb/tb_float_discriminant_collector.sv
// Randomised self-checking bench for float_discriminant_collector (DEPTH=4).
// The reference model is a queue of entries with simple outstanding-issue arithmetic.
module tb_float_discriminant_collector;

    localparam int FLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            arg_vld;
    logic            res_vld;
    logic [FLEN-1:0] res;
    logic            res_negative;
    logic            err;
    logic            can_issue;
    logic            out_vld;
    logic            out_rdy;
    logic [FLEN-1:0] out_res;
    logic            out_negative;
    logic            out_err;
    logic [7:0]      err_count;
    logic            proto_err;

    float_discriminant_collector #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .arg_vld      (arg_vld),
        .res_vld      (res_vld),
        .res          (res),
        .res_negative (res_negative),
        .err          (err),
        .can_issue    (can_issue),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_res      (out_res),
        .out_negative (out_negative),
        .out_err      (out_err),
        .err_count    (err_count),
        .proto_err    (proto_err)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [FLEN-1:0] value;
        logic            neg;
        logic            er;
    } entry_t;

    entry_t mq[$];
    int     mInFlight;
    bit     mProto;
    int     mErrCount;

    int errors = 0;
    int checks = 0;

    function automatic bit expCanIssue();
        return (mq.size() + mInFlight) < DEPTH;
    endfunction

    // Reference behaviour for one clock edge, using the inputs that are currently driven.
    task automatic modelStep();
        bit     pop;
        bit     full;
        bit     pushOk;
        entry_t e;
        pop    = (mq.size() != 0) && out_rdy;
        full   = (mq.size() == DEPTH);
        if (arg_vld && !expCanIssue()) mProto = 1'b1;
        if (res_vld && !arg_vld && mInFlight == 0) mProto = 1'b1;
        pushOk = res_vld && (!full || pop);
        if (res_vld && !pushOk) mProto = 1'b1;
        if (pop) void'(mq.pop_front());
        if (pushOk) begin
            e.value = res;
            e.neg   = res_negative;
            e.er    = err;
            mq.push_back(e);
            if (err && mErrCount < 255) mErrCount++;
        end
        if (arg_vld && !res_vld) begin
            if (mInFlight < DEPTH) mInFlight++;
        end else if (!arg_vld && res_vld) begin
            if (mInFlight > 0) mInFlight--;
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        arg_vld      = 1'b0;
        res_vld      = 1'b0;
        out_rdy      = 1'b0;
        res          = '0;
        res_negative = 1'b0;
        err          = 1'b0;
    endtask

    task automatic modelReset();
        mq.delete();
        mInFlight = 0;
        mProto    = 1'b0;
        mErrCount = 0;
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issueN(input int n);
        for (int i = 0; i < n; i++) begin
            arg_vld = 1'b1;
            tick();
        end
        arg_vld = 1'b0;
    endtask

    task automatic returnVal(input logic [FLEN-1:0] v, input bit neg, input bit er);
        res_vld      = 1'b1;
        res          = v;
        res_negative = neg;
        err          = er;
        tick();
        res_vld = 1'b0;
        err     = 1'b0;
    endtask

    // Reset values are visible while reset is held, before any clock edge.
    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_vld got=%b want=0", out_vld); end
        checks++; if (can_issue !== 1'b1) begin errors++; $display("[TB] FAIL reset_can_issue got=%b want=1", can_issue); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_count got=%0d want=0", err_count); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got=%b want=0", proto_err); end
        checks++; if (out_res !== '0) begin errors++; $display("[TB] FAIL reset_out_res got=%h want=0", out_res); end
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Four issues fill the credit, four results fill the FIFO, then the results drain in order.
    task automatic test_fill_drain();
        logic [FLEN-1:0] vals [4];
        vals[0] = $realtobits(1.0);
        vals[1] = $realtobits(2.0);
        vals[2] = $realtobits(3.0);
        vals[3] = $realtobits(4.0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            checks++; if (can_issue !== 1'b1) begin errors++; $display("[TB] FAIL fill_can_issue_%0d got=%b want=1", i, can_issue); end
            arg_vld = 1'b1;
            tick();
        end
        arg_vld = 1'b0;
        checks++; if (can_issue !== 1'b0) begin errors++; $display("[TB] FAIL fill_credit_exhausted got=%b want=0", can_issue); end
        for (int i = 0; i < 4; i++) begin
            res_vld = 1'b1;
            res     = vals[i];
            if (i == 0) begin
                #1;
                checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_bypass got=%b want=0", out_vld); end
            end
            tick();
            if (i == 0) begin
                checks++; if (out_vld !== 1'b1) begin errors++; $display("[TB] FAIL fill_first_visible got=%b want=1", out_vld); end
            end
        end
        res_vld = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_vld !== 1'b1) begin errors++; $display("[TB] FAIL drain_out_vld_%0d got=%b want=1", i, out_vld); end
            checks++; if (out_res !== vals[i]) begin errors++; $display("[TB] FAIL drain_value_%0d got=%h want=%h", i, out_res, vals[i]); end
            tick();
            if (i == 0) begin
                checks++; if (can_issue !== 1'b1) begin errors++; $display("[TB] FAIL drain_credit_back got=%b want=1", can_issue); end
            end
        end
        out_rdy = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got=%b want=0", out_vld); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL drain_proto_err got=%b want=0", proto_err); end
    endtask

    // Issue whenever allowed into a ten-stage pipeline with the consumer always ready.
    task automatic test_stream();
        bit     pv [10];
        entry_t pe [10];
        int     issued = 0;
        int     dutPops = 0;
        doReset();
        for (int k = 0; k < 10; k++) begin
            pv[k] = 1'b0;
            pe[k] = '0;
        end
        out_rdy = 1'b1;
        for (int c = 0; c < 95; c++) begin
            arg_vld      = (c < 80) ? expCanIssue() : 1'b0;
            res_vld      = pv[9];
            res          = pe[9].value;
            res_negative = pe[9].neg;
            err          = pe[9].er;
            for (int k = 9; k > 0; k--) begin
                pv[k] = pv[k-1];
                pe[k] = pe[k-1];
            end
            pv[0] = arg_vld;
            pe[0] = {{$urandom(), $urandom()}, 1'($urandom()), 1'($urandom())};
            if (arg_vld) issued++;
            checks++; if (can_issue !== expCanIssue()) begin errors++; $display("[TB] FAIL stream_can_issue c=%0d got=%b want=%b", c, can_issue, expCanIssue()); end
            checks++; if (out_vld !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL stream_out_vld c=%0d got=%b want=%b", c, out_vld, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if ({out_res, out_negative, out_err} !== mq[0]) begin errors++; $display("[TB] FAIL stream_head c=%0d got=%h want=%h", c, {out_res, out_negative, out_err}, mq[0]); end
            end
            if (out_vld && out_rdy) dutPops++;
            tick();
        end
        idle();
        checks++; if (dutPops != issued) begin errors++; $display("[TB] FAIL stream_no_loss got=%0d want=%0d", dutPops, issued); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL stream_proto_err got=%b want=0", proto_err); end
    endtask

    // A full FIFO accepts a new result when the head pops in the same cycle, keeping four entries.
    task automatic test_full_push_pop();
        doReset();
        issueN(4);
        for (int i = 0; i < 4; i++) returnVal({$urandom(), $urandom()}, 1'($urandom()), 1'b0);
        for (int i = 0; i < 2; i++) begin
            arg_vld = 1'b1;
            res_vld = 1'b1;
            res     = {$urandom(), $urandom()};
            out_rdy = 1'b1;
            checks++; if (out_res !== mq[0].value) begin errors++; $display("[TB] FAIL fullpp_head_%0d got=%h want=%h", i, out_res, mq[0].value); end
            tick();
            checks++; if (can_issue !== 1'b0) begin errors++; $display("[TB] FAIL fullpp_still_full_%0d got=%b want=0", i, can_issue); end
        end
        idle();
        checks++; if (proto_err !== mProto) begin errors++; $display("[TB] FAIL fullpp_proto got=%b want=%b", proto_err, mProto); end
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({out_vld, out_res} !== {1'b1, mq[0].value}) begin errors++; $display("[TB] FAIL fullpp_drain_%0d got=%b/%h want=1/%h", i, out_vld, out_res, mq[0].value); end
            tick();
        end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL fullpp_empty got=%b want=0", out_vld); end
        out_rdy = 1'b0;
    endtask

    // An extra result into a full FIFO with no pop is dropped and flagged for good.
    task automatic test_drop();
        logic [FLEN-1:0] five;
        five = $realtobits(5.0);
        doReset();
        issueN(4);
        for (int i = 1; i <= 4; i++) returnVal($realtobits(real'(i)), 1'b0, 1'b0);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL drop_pre_proto got=%b want=0", proto_err); end
        returnVal(five, 1'b0, 1'b0);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL drop_proto_set got=%b want=1", proto_err); end
        for (int i = 0; i < 3; i++) tick();
        out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_res === five) begin errors++; $display("[TB] FAIL drop_leaked got=%h want=not 5.0", out_res); end
            checks++; if (out_res !== $realtobits(real'(i))) begin errors++; $display("[TB] FAIL drop_order_%0d got=%h want=%h", i, out_res, $realtobits(real'(i))); end
            tick();
        end
        out_rdy = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL drop_empty got=%b want=0", out_vld); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL drop_proto_sticky got=%b want=1", proto_err); end
    endtask

    // 300 error results saturate the counter at 255.
    task automatic test_err_count();
        doReset();
        out_rdy = 1'b1;
        res_vld = 1'b1;
        err     = 1'b1;
        for (int i = 0; i < 300; i++) begin
            res = {$urandom(), $urandom()};
            tick();
            if (i == 99) begin
                checks++; if (err_count !== 8'(mErrCount)) begin errors++; $display("[TB] FAIL errcnt_mid got=%0d want=%0d", err_count, mErrCount); end
            end
        end
        idle();
        checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL errcnt_saturate got=%0d want=255", err_count); end
        out_rdy = 1'b1;
        tick();
        tick();
        out_rdy = 1'b0;
    endtask

    // Reset mid-operation clears everything at once; a late result then counts as unsolicited.
    task automatic test_reset_mid();
        doReset();
        issueN(4);
        for (int i = 0; i < 3; i++) returnVal({$urandom(), $urandom()}, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_vld got=%b want=0", out_vld); end
        checks++; if (can_issue !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_can_issue got=%b want=1", can_issue); end
        checks++; if (out_res !== '0) begin errors++; $display("[TB] FAIL rstmid_out_res got=%h want=0", out_res); end
        modelReset();
        #1;
        rst = 1'b0;
        returnVal({$urandom(), $urandom()}, 1'b1, 1'b0);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_late_proto got=%b want=1", proto_err); end
        checks++; if ({out_vld, out_res, out_negative} !== {1'b1, mq[0].value, mq[0].neg}) begin errors++; $display("[TB] FAIL rstmid_late_push got=%b/%h want=1/%h", out_vld, out_res, mq[0].value); end
        checks++; if (can_issue !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_no_credit_leak got=%b want=1", can_issue); end
    endtask

    // Random mix of mostly-legal issues, results and pops, compared against the model every cycle.
    task automatic test_random();
        doReset();
        for (int c = 0; c < 300; c++) begin
            arg_vld      = ($urandom_range(0, 9) < 7) ? expCanIssue() : ($urandom_range(0, 19) == 0);
            res_vld      = ($urandom_range(0, 2) == 0);
            res          = {$urandom(), $urandom()};
            res_negative = 1'($urandom());
            err          = 1'($urandom());
            out_rdy      = ($urandom_range(0, 3) != 0);
            checks++; if (can_issue !== expCanIssue()) begin errors++; $display("[TB] FAIL rand_can_issue c=%0d got=%b want=%b", c, can_issue, expCanIssue()); end
            checks++; if (out_vld !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rand_out_vld c=%0d got=%b want=%b", c, out_vld, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if ({out_res, out_negative, out_err} !== mq[0]) begin errors++; $display("[TB] FAIL rand_head c=%0d got=%h want=%h", c, {out_res, out_negative, out_err}, mq[0]); end
            end
            checks++; if (proto_err !== mProto) begin errors++; $display("[TB] FAIL rand_proto c=%0d got=%b want=%b", c, proto_err, mProto); end
            checks++; if (err_count !== 8'(mErrCount)) begin errors++; $display("[TB] FAIL rand_err_count c=%0d got=%0d want=%0d", c, err_count, mErrCount); end
            tick();
        end
        idle();
    endtask

    // Sequence every scenario and report.
    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_push_pop();
        test_drop();
        test_err_count();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
